// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte stores to TX_ADDR are queued in a FIFO and sent 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0002_0004,
    parameter logic [31:0] STAT_ADDR    = 32'h0002_0010,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    state_e        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif
    logic [31:0]   rdata_q;
    logic          hit_q;

    logic        tx_sel, stat_sel, push_req, push, pop, ovf_set, ovf_clr;
    logic        fifo_full, fifo_empty, busy, bit_done;
    logic [7:0]  head;
    logic [31:0] status;
    logic        unused_bits;

    assign tx_sel     = (mem_addr == TX_ADDR);
    assign stat_sel   = (mem_addr == STAT_ADDR);
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push_req   = tx_sel && mem_write[0];
    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign push       = push_req && !fifo_full;
    assign ovf_set    = push_req && fifo_full;
    assign ovf_clr    = stat_sel && mem_write[0] && mem_wdata[2];
    assign head       = fifo_q[rd_ptr_q];
    assign bit_done   = (clk_cnt_q == LAST_CNT);
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign status     = {16'h0, 8'(count_q), 4'h0, busy, ovf_q, fifo_empty, fifo_full};
    assign unused_bits = ^{mem_write[3:1], mem_wdata[31:8], mem_wdata[1:0]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    tx_d      = shift_q[1];
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Both IDLE and end-of-STOP launch the next frame the same way.
        if (pop) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            shift_d   = head;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head;
`endif
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            rdata_q   <= '0;
            hit_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            rdata_q   <= stat_sel ? status : 32'h0;
            hit_q     <= tx_sel || stat_sel;
        end
    end

    assign mem_rdata = rdata_q;
    assign hit       = hit_q;
    assign uart_tx   = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a waveform-queue model checked every cycle, plus directed literal checks.
// Builds with or without UART_TX_PARITY_EN.
module tb_mmio_uart_tx;
    localparam logic [31:0] TX_ADDR   = 32'h0002_0004;
    localparam logic [31:0] STAT_ADDR = 32'h0002_0010;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
    localparam logic [10:0] EXP_55 = 11'h4AA;
    localparam logic [10:0] EXP_07 = 11'h60E;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
    localparam logic [10:0] EXP_55 = 11'h2AA;
    localparam logic [10:0] EXP_07 = 11'h20E;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [3:0]  mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .TX_ADDR(TX_ADDR), .STAT_ADDR(STAT_ADDR),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hit(hit), .uart_tx(uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a byte queue, the line as a queue of per-cycle levels for the frame in flight.
    logic [7:0]  fifo_m[$];
    logic        lvl_m[$];
    bit          ovf_m;
    bit          model_ok = 1'b0;
    logic        exp_tx, exp_hit;
    logic [31:0] exp_rdata;

    always @(posedge clk) begin
        int unsigned sz;
        bit full, busy, push_req, do_pop, lv;
        logic [7:0] b;
        if (!reset) begin
            fifo_m.delete();
            lvl_m.delete();
            ovf_m     = 1'b0;
            exp_tx    = 1'b1;
            exp_hit   = 1'b0;
            exp_rdata = 32'h0;
        end else begin
            sz   = fifo_m.size();
            full = (sz == DEPTH);
            busy = (lvl_m.size() != 0) || (sz != 0);
            exp_hit   = (mem_addr == TX_ADDR) || (mem_addr == STAT_ADDR);
            exp_rdata = (mem_addr == STAT_ADDR) ?
                        ((sz << 8) | (32'(busy) << 3) | (32'(ovf_m) << 2) | (32'(sz == 0) << 1) | 32'(full)) : 32'h0;
            if (lvl_m.size() != 0) void'(lvl_m.pop_front());
            do_pop   = (lvl_m.size() == 0) && (sz != 0);
            push_req = (mem_addr == TX_ADDR) && mem_write[0];
            if (do_pop) begin
                b = fifo_m.pop_front();
                for (int k = 0; k < NB; k++) begin
                    if (k == 0)            lv = 1'b0;
                    else if (k <= 8)       lv = b[k-1];
                    else if (PAR && k == 9) lv = ^b;
                    else                   lv = 1'b1;
                    repeat (CPB) lvl_m.push_back(lv);
                end
            end
            if (push_req && !full) fifo_m.push_back(mem_wdata[7:0]);
            if ((mem_addr == STAT_ADDR) && mem_write[0] && mem_wdata[2]) ovf_m = 1'b0;
            if (push_req && full) ovf_m = 1'b1;
            exp_tx = (lvl_m.size() != 0) ? lvl_m[0] : 1'b1;
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_tx", uart_tx, exp_tx);
            check("model_hit", hit, exp_hit);
            check("model_rdata", mem_rdata, exp_rdata);
        end
    end

    // Passive receiver sampling mid-bit, used to confirm byte order.
    logic [7:0] rx_q[$];
    bit         rx_act = 1'b0;
    int         rx_cnt;
    logic [7:0] rx_sh;
    always @(negedge clk) begin
        if (!rx_act) begin
            if (uart_tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            for (int j = 0; j < 8; j++)
                if (rx_cnt == (j + 1) * CPB + CPB / 2) rx_sh[j] = uart_tx;
            if (rx_cnt == (NB - 1) * CPB + CPB / 2) begin
                rx_q.push_back(rx_sh);
                rx_act = 1'b0;
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        mem_addr  = a;
        mem_write = we;
        mem_wdata = d;
        @(negedge clk);
        mem_addr  = 32'h0;
        mem_write = 4'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_check(input logic [7:0] b, input logic [10:0] exp);
        rx_q.delete();
        bus(TX_ADDR, 4'b0001, {24'h0, b});
        check("line_high_at_store", uart_tx, 1'b1);
        idle(1);
        for (int i = 0; i < NB * CPB; i++) begin
            if (i == 0) check("start_one_edge_late", uart_tx, 1'b0);
            if (i % CPB == 1) check("frame_bit", uart_tx, exp[i / CPB]);
            idle(1);
        end
        check("line_high_after_frame", uart_tx, 1'b1);
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("stat_after_frame", mem_rdata, 32'h0000_0002);
        check("hit_stat", hit, 1'b1);
        check("rx_count", rx_q.size(), 1);
        if (rx_q.size() != 0) check("rx_byte", rx_q[0], b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        mem_addr  = 32'h0;
        mem_write = 4'h0;
        mem_wdata = 32'h0;
        idle(3);
        check("reset_tx", uart_tx, 1'b1);
        check("reset_hit", hit, 1'b0);
        check("reset_rdata", mem_rdata, 32'h0);
        reset = 1'b1;
        idle(2);

        frame_check(8'h55, EXP_55);
        frame_check(8'h07, EXP_07);

        // Store with lane 0 disabled is ignored.
        bus(TX_ADDR, 4'b0010, 32'h0000_0041);
        idle(3);
        check("lane_gate_tx", uart_tx, 1'b1);
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("lane_gate_stat", mem_rdata, 32'h0000_0002);

        // Overflow: ten back-to-back stores, the tenth is dropped.
        rx_q.delete();
        for (int i = 0; i < 10; i++) bus(TX_ADDR, 4'b0001, 32'h30 + i);
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("ovf_stat", mem_rdata, 32'h0000_080D);
        bus(STAT_ADDR, 4'b0001, 32'h0000_0004);
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("ovf_cleared_stat", mem_rdata, 32'h0000_0809);
        idle(9 * NB * CPB + 20);
        check("ovf_rx_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < rx_q.size()) check("ovf_rx_order", rx_q[i], 8'h30 + 8'(i));
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("drained_stat", mem_rdata, 32'h0000_0002);

        // Readback of other addresses.
        bus(32'h0000_1000, 4'b0000, 32'h0);
        check("foreign_hit", hit, 1'b0);
        check("foreign_rdata", mem_rdata, 32'h0);
        bus(TX_ADDR, 4'b0000, 32'h0);
        check("txaddr_hit", hit, 1'b1);
        check("txaddr_rdata", mem_rdata, 32'h0);

        // Reset during the data bits of 0xA5.
        bus(TX_ADDR, 4'b0001, 32'h0000_00A5);
        idle(9);
        check("mid_frame_low_data", uart_tx, 1'b0);
        reset = 1'b0;
        idle(1);
        check("abort_tx", uart_tx, 1'b1);
        check("abort_rdata", mem_rdata, 32'h0);
        reset = 1'b1;
        bus(STAT_ADDR, 4'b0000, 32'h0);
        check("abort_stat", mem_rdata, 32'h0000_0002);
        idle(NB * CPB + 10);
        frame_check(8'h07, EXP_07);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
